uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART transmitter with a valid/ready byte input, optional
//            even/odd parity and one or two stop bits. The serial line is
//            registered and idles high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter logic [12:0] BAUD_CNT_MAX = 13'd433, // last count of a bit period
  parameter int          PARITY_EN    = 0,       // 1: parity bit after data bit 7
  parameter int          PARITY_ODD   = 0,       // 0: even parity, 1: odd parity
  parameter int          STOP_BITS    = 1        // 1 or 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic       PARITY_ODD_BIT = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_STOP      = 3'(STOP_BITS - 1);

  state_t      state, state_nxt;
  logic [12:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        tx_nxt;
  logic        done_nxt;

  logic        baud_wrap;
  logic        parity_bit;
  logic [2:0]  bit_inc;

  // The byte is held unshifted for the whole frame so parity can be taken
  // from the latched value at any time.
  assign baud_wrap  = (baud_cnt == BAUD_CNT_MAX);
  assign parity_bit = (^shreg) ^ PARITY_ODD_BIT;
  assign bit_inc    = bit_cnt + 3'd1;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

  // Next-state and next-register computation; tx is precomputed here so the
  // line only moves on the clock edge that starts a new bit period.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    done_nxt  = 1'b0;

    if (state != IDLE) begin
      baud_nxt = baud_wrap ? 13'd0 : baud_cnt + 13'd1;
    end

    case (state)
      IDLE: begin
        baud_nxt = 13'd0;
        bit_nxt  = 3'd0;
        tx_nxt   = 1'b1;
        if (tx_valid) begin
          shreg_nxt = tx_data;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end

      START: begin
        if (baud_wrap) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
          tx_nxt    = shreg[0];
        end
      end

      DATA: begin
        if (baud_wrap) begin
          if (bit_cnt == 3'd7) begin
            bit_nxt = 3'd0;
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_inc;
            tx_nxt  = shreg[bit_inc];
          end
        end
      end

      PARITY: begin
        if (baud_wrap) begin
          state_nxt = STOP;
          bit_nxt   = 3'd0;
          tx_nxt    = 1'b1;
        end
      end

      STOP: begin
        if (baud_wrap) begin
          if (bit_cnt == LAST_STOP) begin
            state_nxt = IDLE;
            bit_nxt   = 3'd0;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_inc;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        baud_nxt  = 13'd0;
        bit_nxt   = 3'd0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= 13'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx. Four instances cover the default
//            frame, even parity, odd parity and two stop bits. Stimulus pushes
//            the expected frame; one monitor per instance pops and checks it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int BIT   = 434;
  localparam int LIMIT = 10000;

  logic sys_clk = 1'b0;

  // Free-running 100 MHz-style clock.
  always #5 sys_clk = ~sys_clk;

  logic       rstn_w  [4];
  logic [7:0] data_w  [4];
  logic       valid_w [4];
  logic       ready_w [4];
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       par;
    int         len;
    bit         abort;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  uart_tx u_def (
    .sys_clk(sys_clk), .rst_n(rstn_w[0]), .tx_data(data_w[0]), .tx_valid(valid_w[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .sys_clk(sys_clk), .rst_n(rstn_w[1]), .tx_data(data_w[1]), .tx_valid(valid_w[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .sys_clk(sys_clk), .rst_n(rstn_w[2]), .tx_data(data_w[2]), .tx_valid(valid_w[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  uart_tx #(.STOP_BITS(2)) u_stop2 (
    .sys_clk(sys_clk), .rst_n(rstn_w[3]), .tx_data(data_w[3]), .tx_valid(valid_w[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, required %0h", name, id, act, req);
    end
  endtask

  task automatic fail(input string name, input int id, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s dut%0d: got %0d, required %0d", name, id, act, req);
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input int id, input logic [7:0] d, input logic par, input int len,
                      input bit abort, input bit b2b, input bit keep);
    int t = 0;
    data_w[id]  = d;
    valid_w[id] = 1'b1;
    while (ready_w[id] !== 1'b1 && t < LIMIT) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= LIMIT) begin
      fail("send_timeout", id, t, LIMIT);
      valid_w[id] = 1'b0;
      return;
    end
    sb.push_back('{id, d, par, len, abort, b2b});
    @(negedge sys_clk);
    if (!keep) valid_w[id] = 1'b0;
  endtask

  task automatic monitor(input int id);
    int   gap = 1000;
    exp_t e;
    logic bits [16];
    int   nb;
    bit   found, bad, aborted, idle_bad;
    logic s_tx, s_rdy, s_busy, s_done;
    int   s_k;
    idle_bad = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      gap++;
      if (rstn_w[id] !== 1'b1) continue;
      if (tx_w[id] !== 1'b0) begin
        if ((done_w[id] !== 1'b0 || ready_w[id] !== 1'b1 || busy_w[id] !== 1'b0) && !idle_bad) begin
          idle_bad = 1'b1;
          fail("idle_flags(done,ready,busy)", id,
               {done_w[id], ready_w[id], busy_w[id]}, 3'b010);
        end
        continue;
      end
      idle_bad = 1'b0;
      found = 1'b0;
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].id == id) begin
          e = sb[j];
          sb.delete(j);
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        fail("unexpected_frame", id, 1, 0);
        for (int t = 0; t < 6000 && tx_w[id] !== 1'b1; t++) begin
          @(posedge sys_clk); #1;
        end
        continue;
      end
      if (e.b2b) check("b2b_gap_after_done", id, gap, 1);
      nb = e.len / BIT;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = e.data[i];
      for (int i = 9; i < nb; i++) bits[i] = 1'b1;
      if (id == 1 || id == 2) bits[9] = e.par;
      aborted = 1'b0;
      bad     = 1'b0;
      s_k = 0; s_tx = 1'b0; s_rdy = 1'b0; s_busy = 1'b0; s_done = 1'b0;
      for (int k = 0; k < e.len; k++) begin
        if (k > 0) begin
          @(posedge sys_clk); #1;
        end
        if (rstn_w[id] !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (tx_w[id] !== bits[k / BIT] || ready_w[id] !== 1'b0 ||
            busy_w[id] !== 1'b1 || done_w[id] !== 1'b0) begin
          if (!bad) begin
            s_k = k; s_tx = tx_w[id]; s_rdy = ready_w[id];
            s_busy = busy_w[id]; s_done = done_w[id];
          end
          bad = 1'b1;
        end
        if (k % BIT == BIT - 1) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL bit%0d dut%0d byte %0h: got tx=%b ready=%b busy=%b done=%b at clock %0d, required tx=%b ready=0 busy=1 done=0",
                     k / BIT, id, e.data, s_tx, s_rdy, s_busy, s_done, s_k, bits[k / BIT]);
          end
          bad = 1'b0;
        end
      end
      if (aborted) begin
        if (!e.abort) fail("unexpected_abort", id, 1, 0);
        check("tx_after_reset", id, 32'(tx_w[id]), 32'd1);
        check("done_after_reset", id, 32'(done_w[id]), 32'd0);
        gap = 1000;
      end else begin
        @(posedge sys_clk); #1;
        if (e.abort) fail("frame_not_aborted", id, 0, 1);
        check("done_pulse_at_end", id, 32'(done_w[id]), 32'd1);
        check("ready_at_done", id, 32'(ready_w[id]), 32'd1);
        check("tx_idle_at_done", id, 32'(tx_w[id]), 32'd1);
        gap = 0;
      end
    end
  endtask

  // Stimulus: default-config directed cases in one branch, parity and
  // stop-bit variants in the other; then drain the scoreboard and report.
  initial begin
    for (int i = 0; i < 4; i++) begin
      rstn_w[i]  = 1'b0;
      data_w[i]  = 8'h00;
      valid_w[i] = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_tx", i, 32'(tx_w[i]), 32'd1);
      check("reset_ready", i, 32'(ready_w[i]), 32'd1);
      check("reset_busy", i, 32'(busy_w[i]), 32'd0);
      check("reset_done", i, 32'(done_w[i]), 32'd0);
    end
    for (int i = 0; i < 4; i++) rstn_w[i] = 1'b1;
    @(negedge sys_clk);

    fork
      begin
        // 0x55: alternating bits, 4340-clock frame
        send(0, 8'h55, 1'b0, 4340, 1'b0, 1'b0, 1'b0);
        repeat (4400) @(negedge sys_clk);
        // valid held high: 0xA3 then 0x3C back to back
        send(0, 8'hA3, 1'b0, 4340, 1'b0, 1'b0, 1'b1);
        send(0, 8'h3C, 1'b0, 4340, 1'b0, 1'b1, 1'b0);
        repeat (4400) @(negedge sys_clk);
        // 0x12 with a mid-frame 0xFF request and a reset glitch between edges
        send(0, 8'h12, 1'b0, 4340, 1'b0, 1'b0, 1'b0);
        repeat (1000) @(negedge sys_clk);
        data_w[0]  = 8'hFF;
        valid_w[0] = 1'b1;
        @(negedge sys_clk);
        valid_w[0] = 1'b0;
        repeat (500) @(negedge sys_clk);
        #2 rstn_w[0] = 1'b0;
        #2 rstn_w[0] = 1'b1;
        repeat (3000) @(negedge sys_clk);
        // reset for one clock during data bit 3, then a clean 0x81
        send(0, 8'h5A, 1'b0, 4340, 1'b1, 1'b0, 1'b0);
        repeat (1836) @(negedge sys_clk);
        rstn_w[0] = 1'b0;
        @(negedge sys_clk);
        rstn_w[0] = 1'b1;
        repeat (5) @(negedge sys_clk);
        send(0, 8'h81, 1'b0, 4340, 1'b0, 1'b0, 1'b0);
        repeat (4400) @(negedge sys_clk);
      end
      begin
        repeat (20) @(negedge sys_clk);
        fork
          send(1, 8'h07, 1'b1, 4774, 1'b0, 1'b0, 1'b0);
          send(2, 8'h07, 1'b0, 4774, 1'b0, 1'b0, 1'b0);
          send(3, 8'h00, 1'b0, 4774, 1'b0, 1'b0, 1'b0);
        join
        repeat (4850) @(negedge sys_clk);
      end
    join

    for (int t = 0; t < LIMIT && sb.size() != 0; t++) @(negedge sys_clk);
    if (sb.size() != 0) fail("frames_never_sent", -1, sb.size(), 0);
    repeat (50) @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
